// File: rtl/keypad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : keypad_pkg                                                      |
// | Purpose  : Shared types and constants for the 4x3 matrix keypad scanner:  |
// |            FSM state enum, scan-result type, internal key codes, matrix   |
// |            dimensions and the (row, col) -> key code mapping.             |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 3;

  // Internal key codes: digits use their own value (0-9); the two symbol
  // keys take the first codes above the digit range.
  localparam logic [3:0] KEY_DIGIT_MIN = 4'd0;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
  localparam logic [3:0] KEY_STAR      = 4'hA;
  localparam logic [3:0] KEY_HASH      = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEB  = 2'd1,
    ST_HELD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SCAN_NONE  = 2'd0,
    SCAN_KEY   = 2'd1,
    SCAN_MULTI = 2'd2
  } scan_t;

  // Rows 0-2 carry digits 1-9 in reading order; row 3 is '*', '0', '#'.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = KEY_DIGIT_MIN;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : keypad_sync                                                     |
// | Purpose  : Two-flop synchronizer, parameterizable width. Both stages      |
// |            reset to all-ones (the idle level of pulled-up inputs).        |
// | Ports    : clk  - system clock                                            |
// |            rst  - asynchronous active-high reset                          |
// |            i_d  - asynchronous input bus                                  |
// |            o_q  - synchronized output bus                                 |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module keypad_sync
  import keypad_pkg::*;
#(
  parameter int unsigned WIDTH = NUM_COLS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : keypad_scanner                                                  |
// | Purpose  : Scans a 4x3 matrix keypad, debounces presses and releases over |
// |            whole scans, and emits one event per physical press.           |
// | Ports    : clk          - 1 kHz system clock                              |
// |            rst          - asynchronous active-high reset                  |
// |            i_col_n[2:0] - columns, active-low, bit 0 = left column        |
// |            o_row_n[3:0] - one-hot active-low row drive, bit 0 = top row   |
// |            o_num_out    - last accepted digit (0-9), held                 |
// |            o_num_valid  - one-cycle pulse, o_num_out updated              |
// |            o_set_time   - one-cycle pulse on accepted '#'                 |
// |            o_clr_key    - one-cycle pulse on accepted '*'                 |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned DWELL     = 4,  // cycles per row, 3..15
  parameter int unsigned DEB_SCANS = 3   // identical scans to accept, 1..7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_COLS-1:0] i_col_n,
  output logic [NUM_ROWS-1:0] o_row_n,
  output logic [3:0]          o_num_out,
  output logic                o_num_valid,
  output logic                o_set_time,
  output logic                o_clr_key
);

  logic [NUM_COLS-1:0] w_col_n_sync;
  logic [NUM_COLS-1:0] w_low;
  logic [3:0]          r_dwell;
  logic [1:0]          r_row;
  logic [1:0]          w_row_nxt;
  logic [NUM_ROWS-1:0] r_row_n;
  logic                w_dwell_last;
  logic                w_scan_end;

  // Scan accumulator: hit count saturates at 2 (anything >= 2 is MULTI).
  logic [1:0] r_hits;
  logic [3:0] r_code;
  logic [1:0] w_row_hits;
  logic [1:0] w_row_col;
  logic [1:0] w_tot_hits;
  logic [3:0] w_tot_code;
  scan_t      w_result;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_rel, w_rel_nxt;
  logic [3:0] r_cand, w_cand_nxt;
  logic       w_emit;

  keypad_sync #(.WIDTH(NUM_COLS)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .i_d (i_col_n),
    .o_q (w_col_n_sync)
  );

  assign w_low        = ~w_col_n_sync;
  assign w_dwell_last = (r_dwell == 4'(DWELL - 1));
  assign w_scan_end   = w_dwell_last && (r_row == 2'd3);
  assign w_row_nxt    = r_row + 2'd1;

  // Row sequencing: o_row_n is registered so it changes on the edge that
  // starts a dwell, leaving the synchronizer time to settle before sampling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwell <= 4'd0;
      r_row   <= 2'd0;
      r_row_n <= 4'b1110;
    end else if (w_dwell_last) begin
      r_dwell <= 4'd0;
      r_row   <= w_row_nxt;
      r_row_n <= ~(4'b0001 << w_row_nxt);
    end else begin
      r_dwell <= r_dwell + 4'd1;
    end
  end

  // Hits in the row currently sampled; the column of the (last) hit is kept
  // and only used when the row contributes exactly one hit.
  always_comb begin
    w_row_hits = 2'd0;
    w_row_col  = 2'd0;
    for (int c = 0; c < int'(NUM_COLS); c++) begin
      if (w_low[c]) begin
        w_row_col  = 2'(c);
        w_row_hits = (w_row_hits == 2'd0) ? 2'd1 : 2'd2;
      end
    end
  end

  always_comb begin
    w_tot_hits = ((3'(r_hits) + 3'(w_row_hits)) >= 3'd2) ? 2'd2 : (r_hits + w_row_hits);
    w_tot_code = (w_row_hits == 2'd1) ? key_code(r_row, w_row_col) : r_code;
    case (w_tot_hits)
      2'd0:    w_result = SCAN_NONE;
      2'd1:    w_result = SCAN_KEY;
      default: w_result = SCAN_MULTI;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hits <= 2'd0;
      r_code <= 4'd0;
    end else if (w_dwell_last) begin
      // The final row's result is consumed by the FSM this cycle, so the
      // accumulator restarts for the next scan.
      r_hits <= w_scan_end ? 2'd0 : w_tot_hits;
      r_code <= w_scan_end ? 4'd0 : w_tot_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_rel   <= 3'd0;
      r_cand  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rel   <= w_rel_nxt;
      r_cand  <= w_cand_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rel_nxt   = r_rel;
    w_cand_nxt  = r_cand;
    w_emit      = 1'b0;
    if (w_scan_end) begin
      case (r_state)
        ST_IDLE: begin
          if (w_result == SCAN_KEY) begin
            w_cand_nxt = w_tot_code;
            if (DEB_SCANS == 1) begin
              w_emit      = 1'b1;
              w_state_nxt = ST_HELD;
              w_cnt_nxt   = 3'd0;
              w_rel_nxt   = 3'd0;
            end else begin
              w_cnt_nxt   = 3'd1;
              w_state_nxt = ST_DEB;
            end
          end
        end
        ST_DEB: begin
          if ((w_result == SCAN_KEY) && (w_tot_code == r_cand)) begin
            if ((r_cnt + 3'd1) == 3'(DEB_SCANS)) begin
              w_emit      = 1'b1;
              w_state_nxt = ST_HELD;
              w_cnt_nxt   = 3'd0;
              w_rel_nxt   = 3'd0;
            end else begin
              w_cnt_nxt = r_cnt + 3'd1;
            end
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 3'd0;
          end
        end
        ST_HELD: begin
          // A MULTI result still counts as "something is pressed".
          if (w_result == SCAN_NONE) begin
            if ((r_rel + 3'd1) == 3'(DEB_SCANS)) begin
              w_state_nxt = ST_IDLE;
              w_rel_nxt   = 3'd0;
            end else begin
              w_rel_nxt = r_rel + 3'd1;
            end
          end else begin
            w_rel_nxt = 3'd0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 3'd0;
          w_rel_nxt   = 3'd0;
        end
      endcase
    end
  end

  // Strobes are registered: they appear the cycle after the scan-end sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_num_out   <= 4'd0;
      o_num_valid <= 1'b0;
      o_set_time  <= 1'b0;
      o_clr_key   <= 1'b0;
    end else begin
      o_num_valid <= 1'b0;
      o_set_time  <= 1'b0;
      o_clr_key   <= 1'b0;
      if (w_emit) begin
        if (w_tot_code == KEY_HASH) begin
          o_set_time <= 1'b1;
        end else if (w_tot_code == KEY_STAR) begin
          o_clr_key <= 1'b1;
        end else if (w_tot_code <= KEY_DIGIT_MAX) begin
          o_num_out   <= w_tot_code;
          o_num_valid <= 1'b1;
        end
      end
    end
  end

  assign o_row_n = r_row_n;

endmodule
`default_nettype wire
